// File: rtl/bram_transpose_loader.sv
// Buffers ROWS stream words, then writes them to one PIM-array BRAM as
// bit-column slices (LSB slice first), driving port A while the array is in external mode.
module bram_transpose_loader #(
   parameter int ROWS      = 16,
   parameter int WORD_BITS = 160,
   parameter int ADDR_W    = 10,
   parameter int IDX_W     = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   input  logic [IDX_W-1:0]     sel_i,
   input  logic [IDX_W-1:0]     sel_j,
   input  logic [ADDR_W-1:0]    base_addr,
   input  logic                 s_valid,
   output logic                 s_ready,
   input  logic [WORD_BITS-1:0] s_data,
   output logic [IDX_W-1:0]     BRAM_i,
   output logic [IDX_W-1:0]     BRAM_j,
   output logic                 WEA,
   output logic [ADDR_W-1:0]    ADDRA,
   output logic [ROWS-1:0]      DINA,
   output logic                 busy,
   output logic                 done,
   output logic [1:0]           state_dbg
);

   localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
   localparam int CW = (WORD_BITS > 1) ? $clog2(WORD_BITS) : 1;
   localparam logic [RW-1:0] ROW_LAST = RW'(ROWS - 1);
   localparam logic [CW-1:0] COL_LAST = CW'(WORD_BITS - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_FILL  = 2'd1,
      S_WRITE = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t state, state_nxt;

   logic [WORD_BITS-1:0] buffer [ROWS];
   logic [RW-1:0]        row_cnt, row_d;
   logic [CW-1:0]        col_cnt, col_d, col_inc, col_sel;
   logic [ADDR_W-1:0]    base_q, base_d, addra_d;
   logic [IDX_W-1:0]     bram_i_d, bram_j_d;
   logic [ROWS-1:0]      dina_d, slice;
   logic                 s_ready_d, wea_d, busy_d, done_d;
   logic                 accept;

   // Stream handshake: a word transfers on a rising edge where s_valid && s_ready;
   // s_ready is registered and high only in FILL, s_data must hold while s_valid waits.
   assign accept    = s_valid && s_ready;
   assign col_inc   = col_cnt + CW'(1);
   assign state_dbg = state;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= S_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (start) state_nxt = S_FILL;
         S_FILL:  if (accept && (row_cnt == ROW_LAST)) state_nxt = S_WRITE;
         S_WRITE: if (col_cnt == COL_LAST) state_nxt = S_DONE;
         S_DONE:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // Column slice for the next write; on the last FILL accept the final row is
   // not yet in the buffer, so its bit 0 comes straight from s_data.
   always_comb begin
      col_sel = (state == S_WRITE) ? col_inc : '0;
      slice   = '0;
      for (int k = 0; k < ROWS; k++) slice[k] = buffer[k][col_sel];
      if (state == S_FILL) slice[ROWS-1] = s_data[0];
   end

   always_comb begin
      s_ready_d = (state_nxt == S_FILL);
      wea_d     = (state_nxt == S_WRITE);
      busy_d    = (state_nxt != S_IDLE);
      done_d    = (state_nxt == S_DONE);
      bram_i_d  = BRAM_i;
      bram_j_d  = BRAM_j;
      base_d    = base_q;
      addra_d   = ADDRA;
      dina_d    = DINA;
      row_d     = row_cnt;
      col_d     = col_cnt;
      case (state)
         S_IDLE: begin
            if (start) begin
               bram_i_d = sel_i;
               bram_j_d = sel_j;
               base_d   = base_addr;
               row_d    = '0;
            end
         end
         S_FILL: begin
            if (accept) begin
               row_d = row_cnt + RW'(1);
               if (row_cnt == ROW_LAST) begin
                  col_d   = '0;
                  addra_d = base_q;
                  dina_d  = slice;
               end
            end
         end
         S_WRITE: begin
            if (col_cnt != COL_LAST) begin
               col_d   = col_inc;
               addra_d = base_q + ADDR_W'(col_inc);
               dina_d  = slice;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         s_ready <= 1'b0;
         WEA     <= 1'b0;
         busy    <= 1'b0;
         done    <= 1'b0;
         BRAM_i  <= '0;
         BRAM_j  <= '0;
         base_q  <= '0;
         ADDRA   <= '0;
         DINA    <= '0;
         row_cnt <= '0;
         col_cnt <= '0;
      end else begin
         s_ready <= s_ready_d;
         WEA     <= wea_d;
         busy    <= busy_d;
         done    <= done_d;
         BRAM_i  <= bram_i_d;
         BRAM_j  <= bram_j_d;
         base_q  <= base_d;
         ADDRA   <= addra_d;
         DINA    <= dina_d;
         row_cnt <= row_d;
         col_cnt <= col_d;
      end
   end

   always_ff @(posedge clk) begin
      if ((state == S_FILL) && accept) buffer[row_cnt] <= s_data;
   end

endmodule

// File: tb/tb_bram_transpose_loader.sv
// Randomized bench for bram_transpose_loader: a word-level transpose model
// predicts every port-A write, compared against writes captured on the bus.
module tb_bram_transpose_loader;

   localparam int ROWS      = 16;
   localparam int WORD_BITS = 160;
   localparam int ADDR_W    = 10;
   localparam int IDX_W     = 8;
   localparam int EW        = 2*IDX_W + ADDR_W + ROWS;

   logic                 clk = 1'b0;
   logic                 reset, start, s_valid, s_ready, WEA, busy, done;
   logic [IDX_W-1:0]     sel_i, sel_j, BRAM_i, BRAM_j;
   logic [ADDR_W-1:0]    base_addr, ADDRA;
   logic [WORD_BITS-1:0] s_data;
   logic [ROWS-1:0]      DINA;
   logic [1:0]           state_dbg;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   // clock / reset block
   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   bram_transpose_loader #(.ROWS(ROWS), .WORD_BITS(WORD_BITS), .ADDR_W(ADDR_W), .IDX_W(IDX_W)) dut (
      .clk(clk), .reset(reset), .start(start), .sel_i(sel_i), .sel_j(sel_j),
      .base_addr(base_addr), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
      .BRAM_i(BRAM_i), .BRAM_j(BRAM_j), .WEA(WEA), .ADDRA(ADDRA), .DINA(DINA),
      .busy(busy), .done(done), .state_dbg(state_dbg)
   );

   // scoreboard: expected writes {i, j, addr, data} and observed bus writes
   logic [EW-1:0]        exp_q[$];
   logic [EW-1:0]        obs_q[$];
   int                   obs_cyc_q[$];
   int                   done_cnt = 0, done_cyc = 0, hs_cnt = 0, last_hs_cyc = 0;
   logic [WORD_BITS-1:0] words [ROWS];

   always @(negedge clk) begin
      if (reset) begin
         if (WEA) begin
            obs_q.push_back({BRAM_i, BRAM_j, ADDRA, DINA});
            obs_cyc_q.push_back(cyc);
         end
         if (done) begin
            done_cnt++;
            done_cyc = cyc;
         end
         if (s_valid && s_ready) begin
            hs_cnt++;
            last_hs_cyc = cyc;
         end
      end
   end

   // reference model: write c carries bit c of every buffered word, at base+c mod 2^ADDR_W
   function automatic void build_expected(input logic [IDX_W-1:0] i, input logic [IDX_W-1:0] j,
                                          input int base);
      logic [ROWS-1:0]   d;
      logic [ADDR_W-1:0] a;
      exp_q.delete();
      for (int c = 0; c < WORD_BITS; c++) begin
         for (int k = 0; k < ROWS; k++) d[k] = words[k][c];
         a = ADDR_W'((base + c) % (1 << ADDR_W));
         exp_q.push_back({i, j, a, d});
      end
   endfunction

   function automatic logic [WORD_BITS-1:0] rand_word();
      logic [WORD_BITS-1:0] w;
      w = '0;
      for (int b = 0; b < WORD_BITS; b += 32) w = (w << 32) | WORD_BITS'($urandom);
      return w;
   endfunction

   // driver tasks (all entered and left at posedge+1)
   task automatic do_start(input logic [IDX_W-1:0] i, input logic [IDX_W-1:0] j,
                           input logic [ADDR_W-1:0] b);
      sel_i = i; sel_j = j; base_addr = b; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      sel_i = IDX_W'($urandom); sel_j = IDX_W'($urandom); base_addr = ADDR_W'($urandom);
   endtask

   task automatic feed_words(input int gap, output bit ok);
      bit taken;
      int waited;
      ok = 1'b1;
      for (int r = 0; r < ROWS; r++) begin
         s_valid = 1'b1;
         s_data  = words[r];
         taken   = 1'b0;
         waited  = 0;
         while (!taken) begin
            @(negedge clk);
            taken = s_ready;
            @(posedge clk); #1;
            waited++;
            if (!taken && waited > 40) begin
               ok = 1'b0;
               s_valid = 1'b0;
               return;
            end
         end
         s_valid = 1'b0;
         s_data  = rand_word();
         if (gap == 1) begin
            @(posedge clk); #1;
         end else if (gap == 2) begin
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
         end
      end
   endtask

   task automatic wait_done(input int d0, output bit ok);
      ok = 1'b0;
      for (int t = 0; t < 400 && !ok; t++) begin
         @(posedge clk); #1;
         if (done_cnt > d0) ok = 1'b1;
      end
   endtask

   task automatic wait_obs(input int target, output bit ok);
      ok = 1'b0;
      for (int t = 0; t < 400 && !ok; t++) begin
         @(negedge clk); #1;
         if (obs_q.size() >= target) ok = 1'b1;
      end
   endtask

   task automatic test_reset();
      repeat (2) @(posedge clk);
      #1;
      checks++; if (WEA !== 1'b0)     begin errors++; $display("FAIL reset_wea got %b want 0", WEA); end
      checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL reset_s_ready got %b want 0", s_ready); end
      checks++; if (busy !== 1'b0)    begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
      checks++; if (done !== 1'b0)    begin errors++; $display("FAIL reset_done got %b want 0", done); end
      checks++; if ({ADDRA, DINA, BRAM_i, BRAM_j} !== '0)
         begin errors++; $display("FAIL reset_regs got %h/%h/%h/%h want 0", ADDRA, DINA, BRAM_i, BRAM_j); end
      checks++; if (state_dbg !== 2'd0) begin errors++; $display("FAIL reset_state got %0d want 0", state_dbg); end
      #2 reset = 1'b1;
      s_valid = 1'b1; s_data = rand_word();
      repeat (3) @(posedge clk);
      #1;
      checks++; if (hs_cnt !== 0 || s_ready !== 1'b0)
         begin errors++; $display("FAIL idle_valid_ignored got hs=%0d ready=%b want 0/0", hs_cnt, s_ready); end
      s_valid = 1'b0;
   endtask

   task automatic test_pattern_load();
      int m0, n, d0;
      bit ok;
      logic [EW-1:0]   e;
      logic [ROWS-1:0] pat [4];
      pat = '{16'hAAAA, 16'hCCCC, 16'hF0F0, 16'hFF00};
      for (int k = 0; k < ROWS; k++) words[k] = {32'(k), 32'(k), 96'h0};
      build_expected(0, 0, 0);
      m0 = obs_q.size(); d0 = done_cnt;
      do_start(0, 0, 0);
      feed_words(0, ok);
      checks++; if (!ok) begin errors++; $display("FAIL pat_feed got timeout want 16 accepts"); end
      wait_done(d0, ok);
      checks++; if (!ok) begin errors++; $display("FAIL pat_done_wait got timeout want done"); end
      n = obs_q.size() - m0;
      checks++; if (n != WORD_BITS) begin errors++; $display("FAIL pat_count got %0d want %0d", n, WORD_BITS); end
      for (int c = 0; c < n && c < WORD_BITS; c++) begin
         checks++;
         if (obs_q[m0+c] !== exp_q[c]) begin
            errors++; $display("FAIL pat_write[%0d] got %h want %h", c, obs_q[m0+c], exp_q[c]);
         end
      end
      for (int t = 0; t < 8 && n >= WORD_BITS; t++) begin
         e = obs_q[m0 + ((t < 4) ? 96 + t : 124 + t)];
         checks++;
         if (e[ROWS-1:0] !== pat[t % 4]) begin
            errors++; $display("FAIL pat_dina_const[%0d] got %h want %h", t, e[ROWS-1:0], pat[t % 4]);
         end
      end
      checks++; if (done_cnt - d0 != 1) begin errors++; $display("FAIL pat_done_count got %0d want 1", done_cnt - d0); end
      checks++;
      if (n > 0 && done_cyc != obs_cyc_q[m0+n-1] + 1) begin
         errors++; $display("FAIL pat_done_timing got %0d want %0d", done_cyc, obs_cyc_q[m0+n-1] + 1);
      end
   endtask

   task automatic test_backpressure();
      int m0, n, d0, h0, gaps;
      bit ok;
      build_expected(0, 0, 0);
      m0 = obs_q.size(); d0 = done_cnt; h0 = hs_cnt;
      do_start(0, 0, 0);
      feed_words(1, ok);
      wait_done(d0, ok);
      checks++; if (!ok) begin errors++; $display("FAIL bp_done_wait got timeout want done"); end
      checks++; if (hs_cnt - h0 != ROWS) begin errors++; $display("FAIL bp_handshakes got %0d want %0d", hs_cnt - h0, ROWS); end
      n = obs_q.size() - m0;
      checks++; if (n != WORD_BITS) begin errors++; $display("FAIL bp_count got %0d want %0d", n, WORD_BITS); end
      gaps = 0;
      for (int c = 0; c < n && c < WORD_BITS; c++) begin
         checks++;
         if (obs_q[m0+c] !== exp_q[c]) begin
            errors++; $display("FAIL bp_write[%0d] got %h want %h", c, obs_q[m0+c], exp_q[c]);
         end
         if (c > 0 && obs_cyc_q[m0+c] != obs_cyc_q[m0+c-1] + 1) gaps++;
      end
      checks++; if (gaps != 0) begin errors++; $display("FAIL bp_wea_gaps got %0d want 0", gaps); end
      checks++;
      if (n > 0 && obs_cyc_q[m0] != last_hs_cyc + 1) begin
         errors++; $display("FAIL bp_first_wea got cycle %0d want %0d", obs_cyc_q[m0], last_hs_cyc + 1);
      end
   endtask

   task automatic test_selector_sweep();
      int m_all, m0, n, d0;
      bit ok;
      m_all = obs_q.size();
      for (int b = 0; b < 4; b++) begin
         for (int k = 0; k < ROWS; k++) words[k] = rand_word();
         build_expected(IDX_W'(b >> 1), IDX_W'(b & 1), 0);
         m0 = obs_q.size(); d0 = done_cnt;
         do_start(IDX_W'(b >> 1), IDX_W'(b & 1), 0);
         feed_words(2, ok);
         wait_done(d0, ok);
         n = obs_q.size() - m0;
         checks++; if (n != WORD_BITS) begin errors++; $display("FAIL sweep%0d_count got %0d want %0d", b, n, WORD_BITS); end
         for (int c = 0; c < n && c < WORD_BITS; c++) begin
            checks++;
            if (obs_q[m0+c] !== exp_q[c]) begin
               errors++; $display("FAIL sweep%0d_write[%0d] got %h want %h", b, c, obs_q[m0+c], exp_q[c]);
            end
         end
      end
      checks++;
      if (obs_q.size() - m_all != 4 * WORD_BITS) begin
         errors++; $display("FAIL sweep_total got %0d want %0d", obs_q.size() - m_all, 4 * WORD_BITS);
      end
   endtask

   task automatic test_wrap();
      int m0, n, d0, gaps;
      bit ok;
      logic [EW-1:0] e;
      for (int k = 0; k < ROWS; k++) words[k] = rand_word();
      build_expected(8'h3c, 8'h5a, 1000);
      m0 = obs_q.size(); d0 = done_cnt;
      do_start(8'h3c, 8'h5a, 10'd1000);
      feed_words(0, ok);
      wait_done(d0, ok);
      n = obs_q.size() - m0;
      checks++; if (n != WORD_BITS) begin errors++; $display("FAIL wrap_count got %0d want %0d", n, WORD_BITS); end
      gaps = 0;
      for (int c = 0; c < n && c < WORD_BITS; c++) begin
         checks++;
         if (obs_q[m0+c] !== exp_q[c]) begin
            errors++; $display("FAIL wrap_write[%0d] got %h want %h", c, obs_q[m0+c], exp_q[c]);
         end
         if (c > 0 && obs_cyc_q[m0+c] != obs_cyc_q[m0+c-1] + 1) gaps++;
      end
      checks++; if (gaps != 0) begin errors++; $display("FAIL wrap_wea_gaps got %0d want 0", gaps); end
      if (n >= 25) begin
         e = obs_q[m0+23];
         checks++; if (e[ROWS +: ADDR_W] !== 10'd1023) begin errors++; $display("FAIL wrap_addr_top got %0d want 1023", e[ROWS +: ADDR_W]); end
         e = obs_q[m0+24];
         checks++; if (e[ROWS +: ADDR_W] !== 10'd0) begin errors++; $display("FAIL wrap_addr_zero got %0d want 0", e[ROWS +: ADDR_W]); end
      end
   endtask

   task automatic test_start_while_busy();
      int m0, n, d0;
      bit ok;
      for (int k = 0; k < ROWS; k++) words[k] = rand_word();
      build_expected(2, 3, 5);
      m0 = obs_q.size(); d0 = done_cnt;
      do_start(2, 3, 10'd5);
      feed_words(0, ok);
      wait_obs(m0 + 40, ok);
      sel_i = 1; sel_j = 1; base_addr = 10'd77; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      wait_done(d0, ok);
      checks++; if (!ok) begin errors++; $display("FAIL busy_done_wait got timeout want done"); end
      n = obs_q.size() - m0;
      checks++; if (n != WORD_BITS) begin errors++; $display("FAIL busy_count got %0d want %0d", n, WORD_BITS); end
      for (int c = 0; c < n && c < WORD_BITS; c++) begin
         checks++;
         if (obs_q[m0+c] !== exp_q[c]) begin
            errors++; $display("FAIL busy_write[%0d] got %h want %h", c, obs_q[m0+c], exp_q[c]);
         end
      end
      repeat (5) @(posedge clk);
      #1;
      checks++;
      if (busy !== 1'b0 || BRAM_i !== 8'd2 || BRAM_j !== 8'd3) begin
         errors++; $display("FAIL busy_after got busy=%b i=%0d j=%0d want 0/2/3", busy, BRAM_i, BRAM_j);
      end
   endtask

   task automatic test_async_reset();
      int m0, n, d0;
      bit ok;
      for (int k = 0; k < ROWS; k++) words[k] = rand_word();
      m0 = obs_q.size(); d0 = done_cnt;
      do_start(4, 5, 10'd300);
      feed_words(0, ok);
      wait_obs(m0 + 50, ok);
      reset = 1'b0;
      #1;
      checks++; if (WEA !== 1'b0) begin errors++; $display("FAIL areset_wea got %b want 0", WEA); end
      checks++;
      if (state_dbg !== 2'd0 || busy !== 1'b0 || done !== 1'b0) begin
         errors++; $display("FAIL areset_idle got state=%0d busy=%b done=%b want 0/0/0", state_dbg, busy, done);
      end
      @(posedge clk); #2;
      reset = 1'b1;
      n = obs_q.size();
      repeat (20) @(posedge clk);
      #1;
      checks++;
      if (done_cnt != d0 || obs_q.size() != n || busy !== 1'b0) begin
         errors++; $display("FAIL areset_quiet got done=%0d writes=%0d busy=%b want %0d/%0d/0",
                            done_cnt - d0, obs_q.size() - n, busy, 0, 0);
      end
      for (int k = 0; k < ROWS; k++) words[k] = rand_word();
      build_expected(6, 7, 900);
      m0 = obs_q.size(); d0 = done_cnt;
      do_start(6, 7, 10'd900);
      feed_words(2, ok);
      wait_done(d0, ok);
      n = obs_q.size() - m0;
      checks++; if (n != WORD_BITS) begin errors++; $display("FAIL areset_fresh_count got %0d want %0d", n, WORD_BITS); end
      for (int c = 0; c < n && c < WORD_BITS; c++) begin
         checks++;
         if (obs_q[m0+c] !== exp_q[c]) begin
            errors++; $display("FAIL areset_fresh_write[%0d] got %h want %h", c, obs_q[m0+c], exp_q[c]);
         end
      end
   endtask

   task automatic test_back_to_back();
      int m0, n, d0;
      bit ok;
      logic [IDX_W-1:0]  i, j;
      logic [ADDR_W-1:0] b;
      for (int t = 0; t < 3; t++) begin
         for (int k = 0; k < ROWS; k++) words[k] = rand_word();
         i = IDX_W'($urandom); j = IDX_W'($urandom); b = ADDR_W'($urandom_range(0, 1023));
         build_expected(i, j, int'(b));
         m0 = obs_q.size(); d0 = done_cnt;
         checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b%0d_idle_busy got %b want 0", t, busy); end
         do_start(i, j, b);
         feed_words(2, ok);
         wait_done(d0, ok);
         n = obs_q.size() - m0;
         checks++; if (n != WORD_BITS) begin errors++; $display("FAIL b2b%0d_count got %0d want %0d", t, n, WORD_BITS); end
         for (int c = 0; c < n && c < WORD_BITS; c++) begin
            checks++;
            if (obs_q[m0+c] !== exp_q[c]) begin
               errors++; $display("FAIL b2b%0d_write[%0d] got %h want %h", t, c, obs_q[m0+c], exp_q[c]);
            end
         end
      end
   endtask

   initial begin
      reset = 1'b0; start = 1'b0; s_valid = 1'b0; s_data = '0;
      sel_i = '0; sel_j = '0; base_addr = '0;
      test_reset();
      test_pattern_load();
      test_backpressure();
      test_selector_sweep();
      test_wrap();
      test_start_while_busy();
      test_async_reset();
      test_back_to_back();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
